// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Holds the buffered fetch entry, the fetch FSM states and the boot address.
package inst_prefetch_queue_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] BASERAM_BASE = 32'h8000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } pfq_state_t;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Instruction-side Wishbone classic read port between the prefetch queue and the arbiter.
interface inst_prefetch_queue_if
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
);
  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic                  wbm_we_o;
  logic [3:0]            wbm_sel_o;
  logic [ADDR_WIDTH-1:0] wbm_adr_o;
  logic [DATA_WIDTH-1:0] wbm_dat_i;
  logic                  wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/inst_prefetch_queue_fetch_fifo.sv
// Shift-style FIFO of fetch entries; slot 0 is always the head, so the head is a plain register.
// Supports push, pop and a single-cycle flush that dominates both.
module inst_prefetch_queue_fetch_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  fetch_entry_t                   push_data_i,
  input  logic                           pop_i,
  output fetch_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             do_pop, do_push;
  logic [CNT_W-1:0] wr_slot;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && valid_q;
  assign do_push = push_i && (!full_o || do_pop);
  // The write slot accounts for the shift caused by a same-cycle pop.
  assign wr_slot = count_q - CNT_W'(do_pop);

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (do_pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          mem_d[IDX_W'(i)] = mem_q[IDX_W'(i + 1)];
        end
      end
      if (do_push) begin
        mem_d[wr_slot[IDX_W-1:0]] = push_data_i;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = mem_q[0];
  assign count_o = count_q;
  assign empty_o = !valid_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: runs sequential Wishbone word fetches ahead of IF and buffers
// {pc, inst} pairs; a redirect flushes the buffer and restarts fetch at the new PC.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned           DEPTH      = 4,
  parameter int unsigned           ADDR_WIDTH = ADDR_W,
  parameter int unsigned           DATA_WIDTH = DATA_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = BASERAM_BASE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  out_valid_o,
  output logic [ADDR_WIDTH-1:0] out_pc_o,
  output logic [DATA_WIDTH-1:0] out_inst_o,
  input  logic                  out_ready_i,
  inst_prefetch_queue_if.master wbm
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  pfq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  cyc_q, cyc_d;
  logic                  push, pop;
  logic [CNT_W-1:0]      occ_after;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty;
  fetch_entry_t          push_entry, head;

  assign push_entry.pc   = fetch_pc_q;
  assign push_entry.inst = wbm.wbm_dat_i;

  inst_prefetch_queue_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      adr_q      <= RESET_PC;
      cyc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      adr_q      <= adr_d;
      cyc_q      <= cyc_d;
    end
  end

  // Fetch sequencing; a redirect overrides fetch_pc in every state.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    pop        = out_ready_i && out_valid_o && !redirect_i;
    occ_after  = fifo_count + CNT_W'(1) - CNT_W'(pop);
    unique case (state_q)
      IDLE: begin
        if (!redirect_i && !fifo_full) state_d = REQ;
      end
      REQ: begin
        if (wbm.wbm_ack_i) begin
          if (redirect_i) begin
            state_d = IDLE;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            state_d    = (occ_after < CNT_W'(DEPTH)) ? REQ : IDLE;
          end
        end else if (redirect_i) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (wbm.wbm_ack_i) state_d = (redirect_i || fifo_full) ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  end

  // A discarded cycle keeps its original address until the slave acks it.
  always_comb begin
    cyc_d = (state_d != IDLE);
    adr_d = (state_d == REQ) ? fetch_pc_d : adr_q;
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_sel_o = 4'b1111;
  assign wbm.wbm_adr_o = adr_q;

  assign out_valid_o = !fifo_empty;
  assign out_pc_o    = head.pc;
  assign out_inst_o  = head.inst;

endmodule
